tick_rr_scheduler: RTL and testbench

- Programmable divide-by-N tick generator whose tick is shared round-robin among N_REQ requesters. At most one one-cycle grant per tick.
- The divisor is reconfigured through a valid/ready handshake. A new divisor only takes effect at a tick boundary, so no tick period is ever truncated.
- Sits between the clock-enable/divider logic and the periodic consumers (samplers, blinkers, slow FSMs) that need a shared low-rate strobe.

---
 rtl/tick_sched_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/tick_rr_scheduler.sv | 124 ++++++++++++
 tb/tb_tick_rr_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// Shared types and constants for the round-robin tick scheduler.
package tick_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      RECONF = 2'd2
   } sched_state_t;

   localparam int DIV_DEFAULT_P = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last+1 with wrap
// and returns a one-hot grant for the first asserted request.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   input  logic             en,
   output logic [N_REQ-1:0] gnt
);

   logic             found;
   logic [IDX_W-1:0] idx;
   int               idx_wide;

   // Walk the requesters in rotating order starting just after the last winner.
   always_comb begin
      gnt      = '0;
      found    = 1'b0;
      idx      = '0;
      idx_wide = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx_wide = int'(last) + k;
         if (idx_wide >= N_REQ) begin
            idx_wide = idx_wide - N_REQ;
         end
         idx = IDX_W'(idx_wide);
         if (en && !found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tick_rr_scheduler.sv
// Programmable divide-by-N tick generator whose strobe is handed out
// round-robin to N_REQ requesters. Divisor changes land on a tick boundary.
module tick_rr_scheduler
   import tick_sched_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int DIV_W       = 4,
   parameter int DIV_DEFAULT = DIV_DEFAULT_P
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic             tick,
   output logic             busy
);

   localparam int               IDX_W    = $clog2(N_REQ);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);
   localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DIV_DEFAULT);

   sched_state_t     state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] last_q, last_d;

   logic             wrap;
   logic [DIV_W-1:0] cfg_div_eff;

   assign tick        = (state_q != IDLE) && (cnt_q == '0);
   assign busy        = (state_q != IDLE);
   assign wrap        = (cnt_q == div_q - 1'b1);
   assign cfg_div_eff = (cfg_div == '0) ? DIV_W'(1) : cfg_div;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req  (req),
      .last (last_q),
      .en   (tick),
      .gnt  (grant)
   );

   // State, divisor, counter and priority pointer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= DIV_RST;
         cnt_q   <= '0;
         last_q  <= LAST_RST;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   // Next-state, counter advance and divisor handshake.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      cfg_ready = 1'b0;
      case (state_q)
         IDLE: begin
            cfg_ready = 1'b1;
            cnt_d     = '0;
            if (cfg_valid) begin
               div_d = cfg_div_eff;
            end
            if (enable) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = wrap ? '0 : cnt_q + 1'b1;
               if (cfg_valid) begin
                  state_d = RECONF;
               end
            end
         end
         RECONF: begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (wrap) begin
               cfg_ready = 1'b1;
               cnt_d     = '0;
               state_d   = RUN;
               if (cfg_valid) begin
                  div_d = cfg_div_eff;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Remember the most recent winner so the next search starts after it.
   always_comb begin
      last_d = last_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            last_d = IDX_W'(i);
         end
      end
   end

endmodule

// File: tb/tb_tick_rr_scheduler.sv
// Self-checking bench for tick_rr_scheduler with a behavioural model.
module tb_tick_rr_scheduler;

   localparam int N_REQ = 4;
   localparam int DIV_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic             cfg_valid;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_ready;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] grant;
   logic             tick;
   logic             busy;

   int checks = 0;
   int errors = 0;

   // Behavioural model: running flag, reconfiguration pending flag,
   // position within the current tick period, divisor and last winner.
   bit m_run;
   bit m_pend;
   int m_phase;
   int m_div;
   int m_last;

   logic             exp_tick;
   logic             exp_ready;
   logic             exp_busy;
   logic [N_REQ-1:0] exp_grant;

   tick_rr_scheduler #(
      .N_REQ       (N_REQ),
      .DIV_W       (DIV_W),
      .DIV_DEFAULT (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .req       (req),
      .grant     (grant),
      .tick      (tick),
      .busy      (busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   function automatic logic [N_REQ-1:0] model_pick(input logic [N_REQ-1:0] r, input int last);
      for (int k = 1; k <= N_REQ; k++) begin
         int j;
         j = (last + k) % N_REQ;
         if (r[j]) return N_REQ'(1) << j;
      end
      return '0;
   endfunction

   task automatic model_reset();
      m_run   = 1'b0;
      m_pend  = 1'b0;
      m_phase = 0;
      m_div   = 3;
      m_last  = N_REQ - 1;
   endtask

   task automatic apply_stimulus(input logic en, input logic v, input logic [DIV_W-1:0] d,
                                 input logic [N_REQ-1:0] r);
      enable    = en;
      cfg_valid = v;
      cfg_div   = d;
      req       = r;
      #1;
      exp_tick  = m_run && (m_phase == 0);
      exp_busy  = m_run;
      exp_grant = exp_tick ? model_pick(r, m_last) : '0;
      exp_ready = !m_run ? 1'b1 : (m_pend && en && (m_phase == m_div - 1));
   endtask

   task automatic finish_cycle();
      int nd;
      bit boundary;
      nd = (cfg_div == '0) ? 1 : int'(cfg_div);
      for (int i = 0; i < N_REQ; i++) begin
         if (exp_grant[i]) m_last = i;
      end
      if (!m_run) begin
         if (cfg_valid) m_div = nd;
         if (enable) begin
            m_run   = 1'b1;
            m_phase = 0;
            m_pend  = 1'b0;
         end
      end else if (!enable) begin
         m_run   = 1'b0;
         m_phase = 0;
         m_pend  = 1'b0;
      end else begin
         boundary = (m_phase == m_div - 1);
         if (m_pend) begin
            if (boundary && cfg_valid) m_div = nd;
            m_pend = !boundary;
         end else begin
            m_pend = cfg_valid;
         end
         m_phase = boundary ? 0 : m_phase + 1;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      model_reset();
      reset = 1'b1;
      apply_stimulus(1'b0, 1'b0, '0, '0);
      checks++;
      if ({tick, grant, cfg_ready, busy} !== {1'b0, 4'b0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset: tick/grant/ready/busy got %b/%b/%b/%b want 0/0000/1/0",
                  tick, grant, cfg_ready, busy);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_all_req();
      logic [N_REQ-1:0] seq [5];
      int n;
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      n = 0;
      apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
      finish_cycle();
      for (int i = 0; i < 13; i++) begin
         apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
         checks++;
         if ({tick, grant, cfg_ready, busy} !== {exp_tick, exp_grant, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL all_req cycle %0d: tick/grant/ready/busy got %b/%b/%b/%b want %b/%b/%b/%b",
                     i, tick, grant, cfg_ready, busy, exp_tick, exp_grant, exp_ready, exp_busy);
         end
         checks++;
         if (tick !== (i % 3 == 0) || (tick === 1'b1 && n < 5 && grant !== seq[n])) begin
            errors++;
            $display("FAIL all_req_seq cycle %0d: tick/grant got %b/%b want %b/%b",
                     i, tick, grant, (i % 3 == 0), (n < 5) ? seq[n] : 4'b0000);
         end
         if (tick === 1'b1) n++;
         finish_cycle();
      end
   endtask

   task automatic test_sparse_req();
      apply_stimulus(1'b0, 1'b0, '0, 4'b1010);
      finish_cycle();
      apply_stimulus(1'b1, 1'b1, 4'd2, 4'b1010);
      finish_cycle();
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, 1'b0, '0, 4'b1010);
         checks++;
         if ({tick, grant, cfg_ready, busy} !== {exp_tick, exp_grant, exp_ready, exp_busy}
             || (grant & 4'b0101) != 4'b0000) begin
            errors++;
            $display("FAIL sparse cycle %0d: tick/grant/ready/busy got %b/%b/%b/%b want %b/%b/%b/%b",
                     i, tick, grant, cfg_ready, busy, exp_tick, exp_grant, exp_ready, exp_busy);
         end
         finish_cycle();
      end
   endtask

   task automatic test_reconf();
      int waited;
      bit got;
      waited = 0;
      got    = 1'b0;
      apply_stimulus(1'b0, 1'b0, '0, 4'b1111);
      finish_cycle();
      apply_stimulus(1'b1, 1'b1, 4'd4, 4'b1111);
      finish_cycle();
      apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
      finish_cycle();
      for (int i = 0; i < 10 && !got; i++) begin
         apply_stimulus(1'b1, 1'b1, 4'd2, 4'b1111);
         checks++;
         if ({tick, grant, cfg_ready, busy} !== {exp_tick, exp_grant, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL reconf_wait cycle %0d: tick/grant/ready/busy got %b/%b/%b/%b want %b/%b/%b/%b",
                     i, tick, grant, cfg_ready, busy, exp_tick, exp_grant, exp_ready, exp_busy);
         end
         if (cfg_ready === 1'b1) begin
            got    = 1'b1;
            waited = i;
         end
         finish_cycle();
      end
      checks++;
      if (!got || waited != 2) begin
         errors++;
         $display("FAIL reconf_ready: ready seen=%0d after %0d cycles, want 1 after 2", got, waited);
      end
      for (int j = 0; j < 8; j++) begin
         apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
         checks++;
         if ({tick, grant, cfg_ready, busy} !== {exp_tick, exp_grant, exp_ready, exp_busy}
             || tick !== (j % 2 == 0)) begin
            errors++;
            $display("FAIL reconf_period cycle %0d: tick/grant got %b/%b want %b/%b",
                     j, tick, grant, (j % 2 == 0), exp_grant);
         end
         finish_cycle();
      end
   endtask

   task automatic test_div_zero();
      apply_stimulus(1'b0, 1'b0, '0, 4'b1111);
      finish_cycle();
      apply_stimulus(1'b0, 1'b1, 4'd0, 4'b1111);
      finish_cycle();
      apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
      finish_cycle();
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
         checks++;
         if ({tick, grant, cfg_ready, busy} !== {exp_tick, exp_grant, exp_ready, exp_busy}
             || tick !== 1'b1) begin
            errors++;
            $display("FAIL div_zero cycle %0d: tick/grant got %b/%b want 1/%b",
                     i, tick, grant, exp_grant);
         end
         finish_cycle();
      end
   endtask

   task automatic test_enable_drop();
      apply_stimulus(1'b0, 1'b0, '0, 4'b1111);
      finish_cycle();
      apply_stimulus(1'b1, 1'b1, 4'd3, 4'b1111);
      finish_cycle();
      apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
      finish_cycle();
      apply_stimulus(1'b0, 1'b1, 4'd5, 4'b1111);
      finish_cycle();
      apply_stimulus(1'b0, 1'b1, 4'd5, 4'b1111);
      checks++;
      if ({tick, grant, cfg_ready, busy} !== {1'b0, 4'b0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL enable_drop_idle: tick/grant/ready/busy got %b/%b/%b/%b want 0/0000/1/0",
                  tick, grant, cfg_ready, busy);
      end
      finish_cycle();
      apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
      finish_cycle();
      for (int i = 0; i < 11; i++) begin
         apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
         checks++;
         if ({tick, grant, cfg_ready, busy} !== {exp_tick, exp_grant, exp_ready, exp_busy}
             || tick !== (i % 5 == 0)) begin
            errors++;
            $display("FAIL enable_resume cycle %0d: tick/grant got %b/%b want %b/%b",
                     i, tick, grant, (i % 5 == 0), exp_grant);
         end
         finish_cycle();
      end
   endtask

   task automatic test_random();
      logic en;
      logic v;
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 19) != 0);
         v  = ($urandom_range(0, 3) == 0);
         apply_stimulus(en, v, DIV_W'($urandom), N_REQ'($urandom));
         checks++;
         if ({tick, grant, cfg_ready, busy} !== {exp_tick, exp_grant, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL random cycle %0d: tick/grant/ready/busy got %b/%b/%b/%b want %b/%b/%b/%b",
                     i, tick, grant, cfg_ready, busy, exp_tick, exp_grant, exp_ready, exp_busy);
         end
         finish_cycle();
      end
   endtask

   task automatic test_async_reset();
      apply_stimulus(1'b0, 1'b0, '0, 4'b1111);
      finish_cycle();
      apply_stimulus(1'b1, 1'b1, 4'd4, 4'b1111);
      finish_cycle();
      apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
      finish_cycle();
      apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
      finish_cycle();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({tick, grant, cfg_ready, busy} !== {1'b0, 4'b0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: tick/grant/ready/busy got %b/%b/%b/%b want 0/0000/1/0",
                  tick, grant, cfg_ready, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
      finish_cycle();
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(1'b1, 1'b0, '0, 4'b1111);
         checks++;
         if ({tick, grant, cfg_ready, busy} !== {exp_tick, exp_grant, exp_ready, exp_busy}
             || (i == 0 && grant !== 4'b0001) || (i == 3 && grant !== 4'b0010)) begin
            errors++;
            $display("FAIL post_reset cycle %0d: tick/grant got %b/%b want %b/%b",
                     i, tick, grant, exp_tick, exp_grant);
         end
         finish_cycle();
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      req       = '0;
      test_reset();
      test_all_req();
      test_sparse_req();
      test_reconf();
      test_div_zero();
      test_enable_drop();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
